// File: rtl/mux_n_rr_pkg.sv
// Shared constants for the N:1 round-robin stream multiplexer.
package mux_n_rr_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

endpackage

// File: rtl/mux_n_rr_rr_pick.sv
// Combinational round-robin picker: first requester after last, wrapping cyclically.
module rr_pick #(
  parameter int unsigned CHANNELS = 4,
  localparam int unsigned SEL_W   = $clog2(CHANNELS)
) (
  input  logic [CHANNELS-1:0] req,
  input  logic [SEL_W-1:0]    last,
  output logic                found,
  output logic [SEL_W-1:0]    index
);

  always_comb begin
    int unsigned c;
    c     = 0;
    found = 1'b0;
    index = '0;
    // Offsets 1..CHANNELS so that the last granted channel is searched last.
    for (int unsigned i = 1; i <= CHANNELS; i++) begin
      c = (32'(last) + i) % CHANNELS;
      if (!found && req[c[SEL_W-1:0]]) begin
        found = 1'b1;
        index = c[SEL_W-1:0];
      end
    end
  end

endmodule

// File: rtl/mux_n_rr.sv
// N:1 valid/ready stream mux with fixed or round-robin selection and a one-deep output register.
module mux_n_rr
  import mux_n_rr_pkg::*;
#(
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned WIDTH    = 8,
  localparam int unsigned SEL_W   = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      mode,
  input  logic [SEL_W-1:0]          sel,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic [SEL_W-1:0]          out_chan,
  output logic                      out_valid,
  input  logic                      out_ready
);

  logic [WIDTH-1:0] data_q;
  logic [SEL_W-1:0] chan_q;
  logic             valid_q;
  logic [SEL_W-1:0] last_q;

  logic             load_en;
  logic             rr_found;
  logic [SEL_W-1:0] rr_idx;
  logic             fx_found;
  logic             cand_found;
  logic [SEL_W-1:0] cand_idx;
  logic             grant;
  logic [WIDTH-1:0] chan_data [CHANNELS];

  for (genvar i = 0; i < CHANNELS; i++) begin : g_unpack
    assign chan_data[i] = in_data[i*WIDTH +: WIDTH];
  end

  rr_pick #(
    .CHANNELS(CHANNELS)
  ) u_rr_pick (
    .req  (in_valid),
    .last (last_q),
    .found(rr_found),
    .index(rr_idx)
  );

  assign load_en = !valid_q || out_ready;

  // An out-of-range sel (non-power-of-two CHANNELS) never grants.
  assign fx_found = (32'(sel) < CHANNELS) && in_valid[sel];

  always_comb begin
    cand_found = fx_found;
    cand_idx   = sel;
    if (mode == MODE_RR) begin
      cand_found = rr_found;
      cand_idx   = rr_idx;
    end
  end

  // Reset gating keeps in_ready low while rst_n is asserted.
  assign grant = cand_found && load_en && rst_n;

  always_comb begin
    in_ready = '0;
    if (grant) begin
      in_ready[cand_idx] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      chan_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= SEL_W'(CHANNELS - 1);
    end else if (grant) begin
      data_q  <= chan_data[cand_idx];
      chan_q  <= cand_idx;
      valid_q <= 1'b1;
      if (mode == MODE_RR) begin
        last_q <= cand_idx;
      end
    end else if (out_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign out_data  = data_q;
  assign out_chan  = chan_q;
  assign out_valid = valid_q;

endmodule

// File: tb/tb_mux_n_rr.sv
// Self-checking bench for mux_n_rr: directed sequences plus a per-cycle vector table.
module tb_mux_n_rr;

  localparam int unsigned CHANNELS = 4;
  localparam int unsigned WIDTH    = 8;
  localparam int unsigned SEL_W    = 2;
  localparam int unsigned NVEC     = 23;

  logic                      clk;
  logic                      rst_n;
  logic                      mode;
  logic [SEL_W-1:0]          sel;
  logic [CHANNELS*WIDTH-1:0] in_data;
  logic [CHANNELS-1:0]       in_valid;
  logic [CHANNELS-1:0]       in_ready;
  logic [WIDTH-1:0]          out_data;
  logic [SEL_W-1:0]          out_chan;
  logic                      out_valid;
  logic                      out_ready;

  int errors = 0;
  int checks = 0;

  mux_n_rr #(
    .CHANNELS(CHANNELS),
    .WIDTH   (WIDTH)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .mode     (mode),
    .sel      (sel),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_data (out_data),
    .out_chan (out_chan),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        mode;
    logic [1:0]  sel;
    logic [31:0] data;
    logic [3:0]  valid;
    logic        oready;
    logic [3:0]  exp_ready;
    logic        exp_valid;
    logic [1:0]  exp_chan;
    logic [7:0]  exp_data;
  } vec_t;

  vec_t vecs [NVEC];

  function automatic vec_t mk(input logic m, input logic [1:0] s, input logic [31:0] d,
                              input logic [3:0] v, input logic r, input logic [3:0] er,
                              input logic ev, input logic [1:0] ec, input logic [7:0] ed);
    vec_t t;
    t.mode = m; t.sel = s; t.data = d; t.valid = v; t.oready = r;
    t.exp_ready = er; t.exp_valid = ev; t.exp_chan = ec; t.exp_data = ed;
    return t;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  localparam logic [31:0] DA = 32'h13121110;
  localparam logic [31:0] DB = 32'hA5121110;

  initial begin
    logic [7:0] fx_vals [3];
    fx_vals[0] = 8'h11; fx_vals[1] = 8'h22; fx_vals[2] = 8'h33;

    // Fairness, mode switch, back-pressure, sparse RR, fixed corner cases.
    vecs[0]  = mk(1, 0, DA, 4'b1111, 1, 4'b0001, 1, 0, 8'h10);
    vecs[1]  = mk(1, 0, DA, 4'b1111, 1, 4'b0010, 1, 1, 8'h11);
    vecs[2]  = mk(1, 0, DA, 4'b1111, 1, 4'b0100, 1, 2, 8'h12);
    vecs[3]  = mk(1, 0, DA, 4'b1111, 1, 4'b1000, 1, 3, 8'h13);
    vecs[4]  = mk(1, 0, DA, 4'b1111, 1, 4'b0001, 1, 0, 8'h10);
    vecs[5]  = mk(1, 0, DA, 4'b1111, 1, 4'b0010, 1, 1, 8'h11);
    vecs[6]  = mk(0, 0, DA, 4'b1111, 1, 4'b0001, 1, 0, 8'h10);
    vecs[7]  = mk(1, 0, DA, 4'b1111, 1, 4'b0100, 1, 2, 8'h12);
    vecs[8]  = mk(1, 0, DB, 4'b1111, 1, 4'b1000, 1, 3, 8'hA5);
    vecs[9]  = mk(1, 0, DB, 4'b1111, 0, 4'b0000, 1, 3, 8'hA5);
    vecs[10] = mk(1, 0, DB, 4'b1111, 0, 4'b0000, 1, 3, 8'hA5);
    vecs[11] = mk(1, 0, DB, 4'b1111, 0, 4'b0000, 1, 3, 8'hA5);
    vecs[12] = mk(1, 0, DB, 4'b1111, 1, 4'b0001, 1, 0, 8'h10);
    vecs[13] = mk(1, 0, DB, 4'b1000, 1, 4'b1000, 1, 3, 8'hA5);
    vecs[14] = mk(1, 0, DB, 4'b1010, 1, 4'b0010, 1, 1, 8'h11);
    vecs[15] = mk(1, 0, DB, 4'b1010, 1, 4'b1000, 1, 3, 8'hA5);
    vecs[16] = mk(1, 0, DB, 4'b1010, 1, 4'b0010, 1, 1, 8'h11);
    vecs[17] = mk(1, 0, DB, 4'b1010, 1, 4'b1000, 1, 3, 8'hA5);
    vecs[18] = mk(1, 0, DB, 4'b0000, 1, 4'b0000, 0, 3, 8'hA5);
    vecs[19] = mk(0, 1, DB, 4'b1101, 1, 4'b0000, 0, 3, 8'hA5);
    vecs[20] = mk(0, 1, DB, 4'b0010, 1, 4'b0010, 1, 1, 8'h11);
    vecs[21] = mk(0, 1, DB, 4'b0000, 0, 4'b0000, 1, 1, 8'h11);
    vecs[22] = mk(0, 1, DB, 4'b0000, 1, 4'b0000, 0, 1, 8'h11);

    rst_n = 1'b0; mode = 1'b0; sel = '0; in_data = '0; in_valid = '0; out_ready = 1'b1;

    // Reset: in_ready held low even with requests pending.
    in_valid = 4'b1111;
    #3;
    check("ready_in_reset", 32'(in_ready), 32'h0);
    check("valid_in_reset", 32'(out_valid), 32'h0);
    tick();
    check("rst_data", 32'(out_data), 32'h0);
    check("rst_chan", 32'(out_chan), 32'h0);
    in_valid = '0;
    rst_n = 1'b1;

    // Idle for 10 cycles.
    for (int i = 0; i < 10; i++) begin
      #1;
      check($sformatf("idle_ready[%0d]", i), 32'(in_ready), 32'h0);
      tick();
      check($sformatf("idle_valid[%0d]", i), 32'(out_valid), 32'h0);
    end

    // Fixed mode sel=2, back-to-back beats on ch2.
    mode = 1'b0; sel = 2'd2; in_valid = 4'b1111; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_data = {8'hEE, fx_vals[i], 8'hEE, 8'hEE};
      #1;
      check($sformatf("fx_ready[%0d]", i), 32'(in_ready), 32'h4);
      tick();
      check($sformatf("fx_valid[%0d]", i), 32'(out_valid), 32'h1);
      check($sformatf("fx_data[%0d]", i), 32'(out_data), 32'(fx_vals[i]));
      check($sformatf("fx_chan[%0d]", i), 32'(out_chan), 32'h2);
    end
    in_valid = '0;
    tick();
    check("fx_drain_valid", 32'(out_valid), 32'h0);
    check("fx_drain_data", 32'(out_data), 32'h33);

    // Vector table; fixed-mode traffic above left last_grant at 3.
    for (int i = 0; i < int'(NVEC); i++) begin
      mode = vecs[i].mode; sel = vecs[i].sel; in_data = vecs[i].data;
      in_valid = vecs[i].valid; out_ready = vecs[i].oready;
      #1;
      check($sformatf("v%0d_ready", i), 32'(in_ready), 32'(vecs[i].exp_ready));
      tick();
      check($sformatf("v%0d_valid", i), 32'(out_valid), 32'(vecs[i].exp_valid));
      check($sformatf("v%0d_chan", i), 32'(out_chan), 32'(vecs[i].exp_chan));
      check($sformatf("v%0d_data", i), 32'(out_data), 32'(vecs[i].exp_data));
    end

    // Mid-beat async reset: load ch1 in RR mode (last_grant=1), stall, then reset.
    mode = 1'b1; in_data = DA; in_valid = 4'b0010; out_ready = 1'b0;
    tick();
    check("pre_rst_valid", 32'(out_valid), 32'h1);
    check("pre_rst_chan", 32'(out_chan), 32'h1);
    #1;
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", 32'(out_valid), 32'h0);
    check("async_rst_ready", 32'(in_ready), 32'h0);
    tick();
    rst_n = 1'b1;
    in_valid = 4'b1111; out_ready = 1'b1;
    #1;
    check("post_rst_ready", 32'(in_ready), 32'h1);
    tick();
    check("post_rst_chan", 32'(out_chan), 32'h0);
    check("post_rst_data", 32'(out_data), 32'h10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
